// File: rtl/hazard_unit_gen.sv
// rtl/hazard_unit_gen.sv - parametrised hazard/forwarding controller beside the decode stage
// Nearest-stage forwarding, load-use bubbles, multi-cycle branch flush, memory-wait stall, perf counters.
module hazard_unit_gen #(
  parameter  int AW        = 5,
  parameter  int NFWD      = 3,
  parameter  int FLUSH_CYC = 1,
  parameter  int CNTW      = 16,
  localparam int SELW      = $clog2(NFWD + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     rs1_d,
  input  logic [AW-1:0]     rs2_d,
  input  logic              use_rs1,
  input  logic              use_rs2,
  input  logic [NFWD*AW-1:0] rd_flat,
  input  logic [NFWD-1:0]   rb_wr,
  input  logic              ld_ex,
  input  logic              pc_sel,
  input  logic              mem_busy,
  output logic [SELW-1:0]   fwd_a,
  output logic [SELW-1:0]   fwd_b,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_x,
  output logic              flush_d,
  output logic              flush_e,
  output logic [CNTW-1:0]   lu_cnt,
  output logic [CNTW-1:0]   br_cnt,
  output logic [CNTW-1:0]   mw_cnt
);

  typedef enum logic [1:0] {IDLE, FLUSH, MWAIT} state_t;

  localparam int FCW = $clog2(FLUSH_CYC + 1);
  localparam logic [FCW-1:0] FC_FULL   = FCW'(FLUSH_CYC);
  localparam logic [FCW-1:0] FC_RELOAD = FCW'(FLUSH_CYC - 1);

  state_t         state, state_n, eff;
  logic [FCW-1:0] fcnt, fcnt_n;
  logic [AW-1:0]  rd1;
  logic           lu, lu_stall;

  // Scanning from the far stage down lets the nearest matching stage overwrite the result.
  function automatic logic [SELW-1:0] fwd_sel(input logic [AW-1:0] rs, input logic use_rs,
                                              input logic [NFWD*AW-1:0] rds,
                                              input logic [NFWD-1:0] wr);
    fwd_sel = '0;
    for (int k = NFWD; k >= 1; k--) begin
      if (use_rs && (rs != '0) && wr[k-1] && (rds[(k-1)*AW +: AW] == rs))
        fwd_sel = SELW'(k);
    end
  endfunction

  assign fwd_a = rst ? '0 : fwd_sel(rs1_d, use_rs1, rd_flat, rb_wr);
  assign fwd_b = rst ? '0 : fwd_sel(rs2_d, use_rs2, rd_flat, rb_wr);

  assign rd1 = rd_flat[AW-1:0];
  assign lu  = ld_ex & rb_wr[0] & (rd1 != '0) &
               ((use_rs1 & (rd1 == rs1_d)) | (use_rs2 & (rd1 == rs2_d)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    fcnt_n   = fcnt;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_x  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    lu_stall = 1'b0;
    // The cycle mem_busy drops out of MWAIT behaves as the state it will resume.
    eff = state;
    if (state == MWAIT && !mem_busy) eff = (fcnt != '0) ? FLUSH : IDLE;
    if (!rst) begin
      if (mem_busy) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_x = 1'b1;
        state_n = MWAIT;
        if (pc_sel) fcnt_n = FC_FULL;
      end else if (eff == FLUSH) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
        if (pc_sel) begin
          fcnt_n  = FC_RELOAD;
          state_n = (FLUSH_CYC > 1) ? FLUSH : IDLE;
        end else begin
          fcnt_n  = fcnt - FCW'(1);
          state_n = (fcnt == FCW'(1)) ? IDLE : FLUSH;
        end
      end else begin
        state_n = IDLE;
        if (pc_sel) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
          fcnt_n  = FC_RELOAD;
          state_n = (FLUSH_CYC > 1) ? FLUSH : IDLE;
        end else if (lu) begin
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          flush_e  = 1'b1;
          lu_stall = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_cnt <= '0;
      br_cnt <= '0;
      mw_cnt <= '0;
    end else begin
      if (lu_stall && (lu_cnt != '1)) lu_cnt <= lu_cnt + CNTW'(1);
      if (pc_sel && (br_cnt != '1))   br_cnt <= br_cnt + CNTW'(1);
      if (stall_x && (mw_cnt != '1))  mw_cnt <= mw_cnt + CNTW'(1);
    end
  end

endmodule
